// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for a single-port word SRAM without byte enables.
// Sub-word stores run as read-modify-write; loads return the lane-selected, extended word.
module mem_access_ctrl #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [2:0]    dm_ctrl,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          ack,
  output logic          stall,
  output logic          addr_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LBU = 3'b001;
  localparam logic [2:0] LH  = 3'b010;
  localparam logic [2:0] LHU = 3'b011;
  localparam logic [2:0] LW  = 3'b100;
  localparam logic [2:0] SB  = 3'b101;
  localparam logic [2:0] SH  = 3'b110;
  localparam logic [2:0] SW  = 3'b111;

  typedef enum logic [2:0] {IDLE, READ, WAIT, MERGE, WRITE, DONE} state_t;

  state_t       state_q;
  logic [2:0]   ctrl_q;
  logic [AW+1:0] addr_q;
  logic [31:0]  wdata_q;
  logic [31:0]  rdata_q;
  logic [31:0]  merge_q;
  logic         err_q;
  logic         ack_q;
  logic         addr_err_q;
  logic         mem_en_q;
  logic         mem_we_q;

  logic         misaligned;
  logic [7:0]   byte_lane;
  logic [15:0]  half_lane;
  logic [31:0]  load_val;
  logic [31:0]  merge_val;
  logic         unused_addr_hi;

  // Only the word-address and lane bits of the byte address matter to this block.
  assign unused_addr_hi = ^addr[31:AW+2];

  always_comb begin
    misaligned = 1'b0;
    case (dm_ctrl)
      LH, LHU, SH: misaligned = addr[0];
      LW, SW:      misaligned = |addr[1:0];
      default:     misaligned = 1'b0;
    endcase
  end

  always_comb begin
    byte_lane = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      2'd3:    byte_lane = mem_rdata[31:24];
      default: byte_lane = mem_rdata[7:0];
    endcase
    half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_val = mem_rdata;
    case (ctrl_q)
      LB:      load_val = {{24{byte_lane[7]}}, byte_lane};
      LBU:     load_val = {24'h0, byte_lane};
      LH:      load_val = {{16{half_lane[15]}}, half_lane};
      LHU:     load_val = {16'h0, half_lane};
      default: load_val = mem_rdata;
    endcase

    // Only the addressed lane is replaced; the rest of the word is written back as read.
    merge_val = mem_rdata;
    if (ctrl_q == SB) begin
      case (addr_q[1:0])
        2'd1:    merge_val[15:8]  = wdata_q[7:0];
        2'd2:    merge_val[23:16] = wdata_q[7:0];
        2'd3:    merge_val[31:24] = wdata_q[7:0];
        default: merge_val[7:0]   = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_val[31:16] = wdata_q[15:0];
    end else begin
      merge_val[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      merge_q    <= '0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      addr_err_q <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      ack_q      <= 1'b0;
      addr_err_q <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            ctrl_q  <= dm_ctrl;
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
            err_q   <= misaligned;
            if (misaligned) begin
              state_q    <= DONE;
              ack_q      <= 1'b1;
              addr_err_q <= 1'b1;
            end else if (dm_ctrl == SW) begin
              state_q  <= WRITE;
              mem_en_q <= 1'b1;
              mem_we_q <= 1'b1;
            end else begin
              state_q  <= READ;
              mem_en_q <= 1'b1;
            end
          end
        end
        READ: begin
          state_q <= (ctrl_q inside {LB, LBU, LH, LHU, LW}) ? WAIT : MERGE;
        end
        WAIT: begin
          rdata_q    <= load_val;
          state_q    <= DONE;
          ack_q      <= 1'b1;
          addr_err_q <= err_q;
        end
        MERGE: begin
          merge_q  <= merge_val;
          state_q  <= WRITE;
          mem_en_q <= 1'b1;
          mem_we_q <= 1'b1;
        end
        WRITE: begin
          state_q    <= DONE;
          ack_q      <= 1'b1;
          addr_err_q <= err_q;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Reset gates the SRAM strobes so a reset landing in WRITE never commits the store.
  assign mem_en    = mem_en_q & ~reset;
  assign mem_we    = mem_we_q & ~reset;
  assign mem_addr  = addr_q[AW+1:2];
  assign mem_wdata = (ctrl_q == SW) ? wdata_q : merge_q;
  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign addr_err  = addr_err_q;
  assign stall     = req & ~ack_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, reset corner cases, back-to-back
// accesses and random accesses checked against a word-level model of memory.
module tb_mem_access_ctrl;

  localparam int AW = 10;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LBU = 3'b001;
  localparam logic [2:0] LH  = 3'b010;
  localparam logic [2:0] LHU = 3'b011;
  localparam logic [2:0] LW  = 3'b100;
  localparam logic [2:0] SB  = 3'b101;
  localparam logic [2:0] SH  = 3'b110;
  localparam logic [2:0] SW  = 3'b111;
  localparam int NVEC = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic [2:0]    dm_ctrl = 3'b0;
  logic [31:0]   addr = 32'h0;
  logic [31:0]   wdata = 32'h0;
  logic [31:0]   rdata;
  logic          ack;
  logic          stall;
  logic          addr_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0] sram   [0:(1<<AW)-1];
  logic [31:0] refMem [0:15];
  logic        preload = 1'b1;
  logic [31:0] lastRdata = 32'h0;
  bit          reqHeld = 1'b0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] expRd;
    logic        expErr;
    int          expLat;
    logic        expWr;
    logic [31:0] expWord;
  } vec_t;

  vec_t vecs [NVEC];

  mem_access_ctrl #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .req(req), .dm_ctrl(dm_ctrl), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .stall(stall), .addr_err(addr_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  // Synchronous single-port SRAM: read data appears the cycle after an enabled read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) sram[i] <= refMem[i];
    end else if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Expected behaviour from the architectural rules: size/alignment, lane arithmetic, latency.
  function automatic void modelAccess(input logic [2:0] c, input logic [31:0] a, input logic [31:0] wd,
                                      input logic [31:0] prevRd, output logic [31:0] expRd,
                                      output logic expErr, output int expLat,
                                      output logic expWr, output logic [31:0] expWord);
    int off;
    int size;
    logic [31:0] word;
    logic [31:0] v;
    off  = int'(a[1:0]);
    word = refMem[a[5:2]];
    size = (c == LB || c == LBU || c == SB) ? 1 : (c == LH || c == LHU || c == SH) ? 2 : 4;
    expRd = prevRd; expErr = 1'b0; expWr = 1'b0; expWord = 32'h0; expLat = 0;
    if (off % size != 0) begin
      expErr = 1'b1;
      expLat = 1;
      return;
    end
    if (c <= LW) begin
      expLat = 3;
      if (size == 1) begin
        v = (word >> (8 * off)) & 32'hFF;
        if (c == LB && v >= 128) v = v - 32'd256;
      end else if (size == 2) begin
        v = (word >> (16 * (off / 2))) & 32'hFFFF;
        if (c == LH && v >= 32768) v = v - 32'd65536;
      end else begin
        v = word;
      end
      expRd = v;
    end else begin
      expWr = 1'b1;
      if (size == 4) begin
        expLat  = 2;
        expWord = wd;
      end else begin
        v       = (size == 1) ? 32'hFF : 32'hFFFF;
        expLat  = 4;
        expWord = (word & ~(v << (8 * off))) | ((wd & v) << (8 * off));
      end
    end
  endfunction

  task automatic applyStimulus(input logic [2:0] c, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] expRd, input logic expErr, input int expLat,
                               input logic expWr, input logic [31:0] expWord,
                               input bit keepReq, input bit dropMid, input string tag);
    int n, ops, rdCyc, wrCyc, expOps;
    bit acked, stallOk, expStall;
    logic [31:0] rdSeen, wrData;
    logic errSeen;
    logic [AW-1:0] wrAddr, rdAddr;
    if (!reqHeld) @(negedge clk);
    req = 1'b1; dm_ctrl = c; addr = a; wdata = wd;
    stallOk = 1'b1;
    if (reqHeld) begin
      @(negedge clk);
      if (stall !== 1'b1 || ack !== 1'b0) stallOk = 1'b0;
    end
    n = 0; ops = 0; rdCyc = 0; wrCyc = 0; acked = 1'b0;
    rdSeen = ~expRd; errSeen = ~expErr; wrData = 32'h0; wrAddr = '0; rdAddr = '0;
    while (!acked && n < 12) begin
      @(negedge clk);
      n++;
      if (mem_en === 1'b1) begin
        ops++;
        if (mem_we === 1'b1) begin wrCyc = n; wrAddr = mem_addr; wrData = mem_wdata; end
        else begin rdCyc = n; rdAddr = mem_addr; end
      end
      expStall = req && (n != expLat);
      if (stall !== expStall) stallOk = 1'b0;
      if (ack === 1'b1) begin
        acked = 1'b1; rdSeen = rdata; errSeen = addr_err;
      end
      if (dropMid && n == 1 && !acked) begin
        req = 1'b0; dm_ctrl = 3'($urandom_range(7, 0)); addr = $urandom; wdata = $urandom;
      end
    end
    if (expErr) expOps = 0; else if (c == SB || c == SH) expOps = 2; else expOps = 1;
    checkOutput({tag, " latency"}, 32'(n), 32'(expLat));
    checkOutput({tag, " addr_err"}, 32'(errSeen), 32'(expErr));
    checkOutput({tag, " rdata"}, rdSeen, expRd);
    checkOutput({tag, " sram ops"}, 32'(ops), 32'(expOps));
    checkOutput({tag, " stall"}, 32'(stallOk), 32'd1);
    if (expWr) begin
      checkOutput({tag, " write cycle"}, 32'(wrCyc), (expLat == 2) ? 32'd1 : 32'd3);
      checkOutput({tag, " write addr"}, 32'(wrAddr), 32'(a[AW+1:2]));
      checkOutput({tag, " write data"}, wrData, expWord);
    end else begin
      checkOutput({tag, " no write"}, 32'(wrCyc), 32'd0);
    end
    if (!expErr && c != SW) begin
      checkOutput({tag, " read cycle"}, 32'(rdCyc), 32'd1);
      checkOutput({tag, " read addr"}, 32'(rdAddr), 32'(a[AW+1:2]));
    end
    if (expWr) refMem[a[5:2]] = expWord;
    lastRdata = expRd;
    reqHeld = keepReq;
    if (!keepReq) req = 1'b0;
  endtask

  task automatic runModel(input logic [2:0] c, input logic [31:0] a, input logic [31:0] wd,
                          input bit keepReq, input bit dropMid, input string tag);
    logic [31:0] er, ew;
    logic ee, wr;
    int lat;
    modelAccess(c, a, wd, lastRdata, er, ee, lat, wr, ew);
    applyStimulus(c, a, wd, er, ee, lat, wr, ew, keepReq, dropMid, tag);
  endtask

  initial begin
    logic sawWe;
    vecs[0]  = '{LB,  32'h12, 32'h0,        32'hFFFFFFFF, 1'b0, 3, 1'b0, 32'h0};
    vecs[1]  = '{LB,  32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1'b0, 32'h0};
    vecs[2]  = '{LBU, 32'h13, 32'h0,        32'h00000080, 1'b0, 3, 1'b0, 32'h0};
    vecs[3]  = '{LBU, 32'h10, 32'h0,        32'h00000001, 1'b0, 3, 1'b0, 32'h0};
    vecs[4]  = '{LH,  32'h12, 32'h0,        32'hFFFF80FF, 1'b0, 3, 1'b0, 32'h0};
    vecs[5]  = '{LHU, 32'h12, 32'h0,        32'h000080FF, 1'b0, 3, 1'b0, 32'h0};
    vecs[6]  = '{LH,  32'h10, 32'h0,        32'h00007F01, 1'b0, 3, 1'b0, 32'h0};
    vecs[7]  = '{LW,  32'h10, 32'h0,        32'h80FF7F01, 1'b0, 3, 1'b0, 32'h0};
    vecs[8]  = '{SH,  32'h12, 32'hCAFE1234, 32'h0,        1'b0, 4, 1'b1, 32'h12347F01};
    vecs[9]  = '{SB,  32'h10, 32'h555555AA, 32'h0,        1'b0, 4, 1'b1, 32'h12347FAA};
    vecs[10] = '{LW,  32'h11, 32'h0,        32'h0,        1'b1, 1, 1'b0, 32'h0};
    vecs[11] = '{SH,  32'h13, 32'h0000FFFF, 32'h0,        1'b1, 1, 1'b0, 32'h0};
    vecs[12] = '{LH,  32'h11, 32'h0,        32'h0,        1'b1, 1, 1'b0, 32'h0};
    vecs[13] = '{SW,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1'b1, 32'hDEADBEEF};
    vecs[14] = '{LW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1'b0, 32'h0};
    vecs[15] = '{LBU, 32'h11, 32'h0,        32'h000000BE, 1'b0, 3, 1'b0, 32'h0};
    vecs[16] = '{SB,  32'h13, 32'h00000011, 32'h0,        1'b0, 4, 1'b1, 32'h11ADBEEF};
    vecs[17] = '{SW,  32'h12, 32'h01020304, 32'h0,        1'b1, 1, 1'b0, 32'h0};
    vecs[18] = '{LH,  32'h12, 32'h0,        32'h000011AD, 1'b0, 3, 1'b0, 32'h0};
    vecs[19] = '{LB,  32'h12, 32'h0,        32'hFFFFFFAD, 1'b0, 3, 1'b0, 32'h0};

    for (int i = 0; i < 16; i++) refMem[i] = $urandom;
    refMem[4] = 32'h80FF7F01;

    repeat (3) @(negedge clk);
    preload = 1'b0;
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset mem_wdata", mem_wdata, 32'h0);
    checkOutput("reset controls", 32'({ack, addr_err, mem_en, mem_we, stall, mem_addr}), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      logic [31:0] er;
      er = (vecs[i].ctrl <= LW && !vecs[i].expErr) ? vecs[i].expRd : lastRdata;
      applyStimulus(vecs[i].ctrl, vecs[i].a, vecs[i].wd, er, vecs[i].expErr, vecs[i].expLat,
                    vecs[i].expWr, vecs[i].expWord, 1'b0, 1'b0, $sformatf("vec%0d", i));
    end

    // Reset while an SB sits in MERGE: the store must be abandoned.
    @(negedge clk);
    req = 1'b1; dm_ctrl = SB; addr = 32'h14; wdata = 32'h00000077;
    @(negedge clk);
    checkOutput("rstMerge read strobe", 32'({mem_en, mem_we}), 32'h2);
    @(negedge clk);
    sawWe = mem_we;
    reset = 1'b1; req = 1'b0;
    @(negedge clk);
    sawWe = sawWe | mem_we;
    checkOutput("rstMerge no write", 32'(sawWe), 32'h0);
    checkOutput("rstMerge rdata", rdata, 32'h0);
    checkOutput("rstMerge mem_wdata", mem_wdata, 32'h0);
    checkOutput("rstMerge controls", 32'({ack, addr_err, mem_en, mem_we, stall, mem_addr}), 32'h0);
    checkOutput("rstMerge sram word", sram[5], refMem[5]);
    reset = 1'b0; lastRdata = 32'h0;
    runModel(LW, 32'h14, 32'h0, 1'b0, 1'b0, "rstMerge lw");

    // Reset in the WRITE cycle of an SW drops the strobe immediately.
    @(negedge clk);
    req = 1'b1; dm_ctrl = SW; addr = 32'h18; wdata = 32'h12345678;
    @(negedge clk);
    checkOutput("rstWrite we before", 32'(mem_we), 32'h1);
    reset = 1'b1; req = 1'b0;
    #1;
    checkOutput("rstWrite strobes gated", 32'({mem_en, mem_we}), 32'h0);
    @(negedge clk);
    reset = 1'b0; lastRdata = 32'h0;
    checkOutput("rstWrite sram word", sram[6], refMem[6]);
    runModel(LW, 32'h18, 32'h0, 1'b0, 1'b0, "rstWrite lw");

    runModel(LW, 32'h10, 32'h0,        1'b1, 1'b0, "b2b0");
    runModel(SW, 32'h20, 32'h0BADF00D, 1'b1, 1'b0, "b2b1");
    runModel(LW, 32'h20, 32'h0,        1'b1, 1'b0, "b2b2");
    runModel(SW, 32'h24, 32'h13579BDF, 1'b1, 1'b0, "b2b3");
    runModel(LW, 32'h24, 32'h0,        1'b0, 1'b0, "b2b4");

    for (int i = 0; i < 60; i++) begin
      logic [2:0] c;
      logic [31:0] a;
      bit keep, drop;
      c    = 3'($urandom_range(7, 0));
      a    = 32'($urandom_range(63, 0));
      drop = ($urandom_range(5, 0) == 0);
      keep = !drop && ($urandom_range(3, 0) == 0);
      runModel(c, a, $urandom, keep, drop, $sformatf("rnd%0d", i));
    end
    req = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
